// File: rtl/booth_r4_mult.sv
// Radix-4 Booth sequential multiplier with a start/done handshake and signed/unsigned operand mode.
// Optional early termination on a uniform remaining multiplier: define BOOTH_EARLY_TERM_EN.
module booth_r4_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   outR
);

  localparam int unsigned N_ITER = WIDTH / 2 + 1;
  localparam int unsigned EW     = WIDTH + 2;
  localparam int unsigned PW     = 2 * WIDTH + 2;
  localparam int unsigned CNT_W  = $clog2(N_ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      m_q, m_d;
  logic [EW-1:0]      q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] outr_q, outr_d;

  logic [PW-1:0]      addend_c;
  logic [PW-1:0]      m_x2_c;
  logic               ext_a_c;
  logic               ext_b_c;
  logic               unused_acc_msbs;

  // Booth digit selection from (q1, q0, q-1)
  always_comb begin
    m_x2_c   = {m_q[PW-2:0], 1'b0};
    addend_c = '0;
    unique case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: addend_c = m_q;
      3'b011:         addend_c = m_x2_c;
      3'b100:         addend_c = ~m_x2_c + PW'(1);
      3'b101, 3'b110: addend_c = ~m_q + PW'(1);
      default:        addend_c = '0;
    endcase
  end

  assign ext_a_c = signed_mode & A[WIDTH-1];
  assign ext_b_c = signed_mode & B[WIDTH-1];

  // Controller and datapath next-state
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    outr_d  = outr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = {{(PW - WIDTH){ext_a_c}}, A};
          q_d     = {{2{ext_b_c}}, B};
          qm1_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = acc_q + addend_c;
        m_d   = {m_q[PW-3:0], 2'b00};
        q_d   = {{2{q_q[EW-1]}}, q_q[EW-1:2]};
        qm1_d = q_q[1];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_ITER - 1)) begin
          state_d = S_DONE;
        end
`ifdef BOOTH_EARLY_TERM_EN
        // all remaining digits are zero once Q and q-1 are uniform
        else if ((&{q_d, qm1_d}) || !(|{q_d, qm1_d})) begin
          state_d = S_DONE;
        end
`endif
      end
      S_DONE: begin
        outr_d  = acc_q[2*WIDTH-1:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      outr_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      outr_q  <= outr_d;
    end
  end

  // Guard bits only absorb intermediate overflow; the product is the low 2*WIDTH bits
  assign unused_acc_msbs = ^acc_q[PW-1:2*WIDTH];

  assign busy = busy_q;
  assign done = done_q;
  assign outR = outr_q;

endmodule
